// File: rtl/trash_insn_loader.sv
// rtl/trash_insn_loader.sv - byte-pair instruction loader with show-ahead word FIFO
module trash_insn_loader #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               byte_in,
    input  logic                     byte_valid,
    output logic                     byte_ready,
    input  logic                     sync,
    input  logic                     flush,
    output logic [15:0]              insn,
    output logic                     insn_valid,
    input  logic                     insn_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     frag_err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic {LO = 1'b0, HI = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [7:0]      low_q, low_d;
    logic            frag_q, frag_d;
    logic [15:0]     mem_q [DEPTH];

    logic            full;
    logic            xfer;
    logic            push;
    logic            pop;

    // Full ignores a same-cycle pop so the byte handshake never depends on insn_ready.
    assign full       = (count_q == FULL_CNT);
    assign byte_ready = (state_q == LO) || !full;
    assign insn_valid = (count_q != '0);
    assign insn       = insn_valid ? mem_q[rd_ptr_q] : 16'h0000;
    assign count      = count_q;
    assign frag_err   = frag_q;

    assign xfer = byte_valid && byte_ready;
    assign pop  = insn_valid && insn_ready && !flush && !reset;
    // A byte arriving with sync starts a new word, so it never completes the old one.
    assign push = xfer && (state_q == HI) && !sync && !flush && !reset;

    // Next-state computation for pairing FSM, pointers, count and sticky error.
    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        low_d    = low_q;
        frag_d   = frag_q;

        if (flush) begin
            state_d  = LO;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            frag_d   = 1'b0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + (AW+1)'(1);
            end else if (pop && !push) begin
                count_d = count_q - (AW+1)'(1);
            end

            if (sync) begin
                if (state_q == HI) begin
                    frag_d = 1'b1;
                end
                if (xfer) begin
                    low_d   = byte_in;
                    state_d = HI;
                end else begin
                    state_d = LO;
                end
            end else if (xfer) begin
                if (state_q == LO) begin
                    low_d   = byte_in;
                    state_d = HI;
                end else begin
                    state_d = LO;
                end
            end
        end
    end

    // Control state register; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= LO;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            frag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            frag_q   <= frag_d;
        end
    end

    // Held low byte and word storage carry no reset.
    always_ff @(posedge clk) begin
        low_q <= low_d;
        if (push) begin
            mem_q[wr_ptr_q] <= {byte_in, low_q};
        end
    end
endmodule

// File: tb/tb_trash_insn_loader.sv
// tb/tb_trash_insn_loader.sv - scoreboard bench for trash_insn_loader
module tb_trash_insn_loader;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        sync;
    logic        flush;
    logic [15:0] insn;
    logic        insn_valid;
    logic        insn_ready;
    logic [2:0]  count;
    logic        frag_err;

    trash_insn_loader #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .sync       (sync),
        .flush      (flush),
        .insn       (insn),
        .insn_valid (insn_valid),
        .insn_ready (insn_ready),
        .count      (count),
        .frag_err   (frag_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int fails   = 0;

    logic [15:0] m_q[$];
    logic        m_state = 1'b0;
    logic [7:0]  m_low   = 8'h00;
    logic        m_frag  = 1'b0;
    logic        m_ok    = 1'b0;

    logic        last_pop;
    logic [15:0] last_word;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: compare DUT with the reference model, advance the model, step past the edge.
    task automatic cyc();
        logic rdy, xf, pp, ps;
        #3;
        rdy = (m_state == 1'b0) || (m_q.size() < DEPTH);
        if (m_ok) begin
            chk("byte_ready", {31'd0, byte_ready}, {31'd0, rdy});
            chk("insn_valid", {31'd0, insn_valid}, (m_q.size() != 0) ? 32'd1 : 32'd0);
            chk("insn", {16'd0, insn}, (m_q.size() != 0) ? {16'd0, m_q[0]} : 32'd0);
            chk("count", {29'd0, count}, m_q.size());
            chk("frag_err", {31'd0, frag_err}, {31'd0, m_frag});
        end
        last_pop  = insn_valid && insn_ready;
        last_word = insn;
        if (reset || flush) begin
            m_state = 1'b0;
            m_q.delete();
            m_frag  = 1'b0;
            if (reset) m_ok = 1'b1;
        end else begin
            xf = byte_valid && rdy;
            pp = (m_q.size() != 0) && insn_ready;
            ps = xf && m_state && !sync;
            if (pp) void'(m_q.pop_front());
            if (ps) m_q.push_back({byte_in, m_low});
            if (sync) begin
                if (m_state) m_frag = 1'b1;
                if (xf) begin
                    m_low   = byte_in;
                    m_state = 1'b1;
                end else begin
                    m_state = 1'b0;
                end
            end else if (xf) begin
                if (!m_state) begin
                    m_low   = byte_in;
                    m_state = 1'b1;
                end else begin
                    m_state = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_in    = b;
        cyc();
        byte_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        insn_ready = 1'b1;
        repeat (n) cyc();
        insn_ready = 1'b0;
    endtask

    initial begin
        int popped;
        int max_cnt;
        logic tog;
        reset = 1'b1; byte_in = 8'h00; byte_valid = 1'b0; sync = 1'b0;
        flush = 1'b0; insn_ready = 1'b0;
        @(posedge clk);
        #1;
        cyc();
        reset = 1'b0;
        #3;
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_valid", {31'd0, insn_valid}, 32'd0);
        chk("rst_insn", {16'd0, insn}, 32'd0);
        chk("rst_frag", {31'd0, frag_err}, 32'd0);
        chk("rst_ready", {31'd0, byte_ready}, 32'd1);
        @(posedge clk);
        #1;

        // basic pairing
        send(8'h23);
        send(8'h45);
        #3;
        chk("pair_insn", {16'd0, insn}, 32'h4523);
        chk("pair_valid", {31'd0, insn_valid}, 32'd1);
        chk("pair_count", {29'd0, count}, 32'd1);
        @(posedge clk);
        #1;
        drain(2);

        // full backpressure
        byte_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            byte_in = 8'h10 + 8'(i);
            cyc();
        end
        #3;
        chk("full_count", {29'd0, count}, 32'd4);
        chk("full_ready", {31'd0, byte_ready}, 32'd0);
        @(posedge clk);
        #1;
        byte_in = 8'h91;
        repeat (3) cyc();
        chk("held_count", {29'd0, count}, 32'd4);
        insn_ready = 1'b1;
        cyc();
        insn_ready = 1'b0;
        cyc();
        byte_valid = 1'b0;
        #3;
        chk("refill_count", {29'd0, count}, 32'd4);
        @(posedge clk);
        #1;
        drain(5);

        // order and wrap with toggling consumer
        popped = 0; max_cnt = 0; tog = 1'b0;
        for (int i = 0; i < 32; i++) begin
            byte_valid = (i < 12);
            byte_in    = 8'((i / 2) + 1);
            insn_ready = tog;
            tog = ~tog;
            cyc();
            if (last_pop) begin
                popped++;
                chk("wrap_order", {16'd0, last_word}, {16'd0, 8'(popped), 8'(popped)});
            end
            if (int'(count) > max_cnt) max_cnt = int'(count);
        end
        byte_valid = 1'b0; insn_ready = 1'b0;
        chk("wrap_pops", popped, 32'd6);
        chk("wrap_max", {31'd0, max_cnt <= DEPTH}, 32'd1);

        // resync discards a partial word
        send(8'hAA);
        sync = 1'b1;
        cyc();
        sync = 1'b0;
        send(8'h11);
        send(8'h22);
        #3;
        chk("sync_frag", {31'd0, frag_err}, 32'd1);
        chk("sync_insn", {16'd0, insn}, 32'h2211);
        @(posedge clk);
        #1;
        drain(1);

        // byte arriving with sync becomes the new low byte
        send(8'h55);
        sync = 1'b1;
        send(8'h66);
        sync = 1'b0;
        send(8'h77);
        #3;
        chk("sync_byte_insn", {16'd0, insn}, 32'h7766);
        @(posedge clk);
        #1;
        drain(1);

        // flush overrides everything
        for (int i = 0; i < 7; i++) send(8'hC0 + 8'(i));
        flush = 1'b1; byte_valid = 1'b1; byte_in = 8'hEE; insn_ready = 1'b1;
        cyc();
        flush = 1'b0; byte_valid = 1'b0; insn_ready = 1'b0;
        #3;
        chk("flush_count", {29'd0, count}, 32'd0);
        chk("flush_valid", {31'd0, insn_valid}, 32'd0);
        chk("flush_frag", {31'd0, frag_err}, 32'd0);
        @(posedge clk);
        #1;
        send(8'h33);
        send(8'h44);
        #3;
        chk("flush_lo_insn", {16'd0, insn}, 32'h4433);
        @(posedge clk);
        #1;
        drain(1);

        // reset mid-word
        send(8'h7F);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        send(8'h01);
        send(8'h80);
        #3;
        chk("rstmid_insn", {16'd0, insn}, 32'h8001);
        chk("rstmid_count", {29'd0, count}, 32'd1);
        @(posedge clk);
        #1;
        drain(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule

// File: doc/trash_insn_loader.md
TRASH_INSN_LOADER -- requirements
Module: trash_insn_loader

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, giving the FIFO depth in 16-bit words (power of two, >= 2).
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The module SHALL have port byte_in, input, 8, the incoming instruction byte.
REQ-005 The module SHALL have port byte_valid, input, 1, high when byte_in holds a byte.
REQ-006 The module SHALL have port byte_ready, output, 1, high when the current byte can be accepted.
REQ-007 The module SHALL have port sync, input, 1, which resynchronises byte pairing (discards any partial word).
REQ-008 The module SHALL have port flush, input, 1, which empties the FIFO and resets pairing.
REQ-009 The module SHALL have port insn, output, 16, the head-of-FIFO instruction word.
REQ-010 The module SHALL have port insn_valid, output, 1, high when the FIFO is non-empty.
REQ-011 The module SHALL have port insn_ready, input, 1, driven by the consuming core.
REQ-012 The module SHALL have port count, output, clog2(DEPTH)+1, the number of stored words.
REQ-013 The module SHALL have port frag_err, output, 1, a sticky flag for a discarded partial word.

Function
REQ-014 The module SHALL implement a two-state pairing FSM: LO (expecting low byte) and HI (low byte held, expecting high byte).
REQ-015 In LO, byte_ready SHALL be 1; a byte transfer SHALL latch byte_in as the low byte and move to HI.
REQ-016 In HI, byte_ready SHALL equal !full; a byte transfer SHALL push {byte_in, low_byte} (high byte in insn[15:8]) and return to LO.
REQ-017 A byte transfer SHALL occur only when byte_valid && byte_ready; in HI with full FIFO, the byte SHALL stay pending, with no state change.
REQ-018 A pop SHALL occur when insn_valid && insn_ready; the read pointer advances at that edge.
REQ-019 insn SHALL show the head word combinationally (show-ahead), and SHALL be 16'h0000 when the FIFO is empty.
REQ-020 Push latency SHALL be one cycle: a word pushed at edge N makes insn_valid high from edge N; there SHALL be no same-cycle bypass.
REQ-021 On a simultaneous push and pop, count SHALL be unchanged, and both pointers SHALL advance.
REQ-022 The full decision SHALL ignore a same-cycle pop: at count == DEPTH, byte_ready in HI is 0 even if insn_ready is 1.
REQ-023 Pointers SHALL wrap modulo DEPTH, and count SHALL never exceed DEPTH or underflow below 0.
REQ-024 sync SHALL force the FSM to LO; if the FSM was in HI, frag_err SHALL be set to 1.
REQ-025 A byte transferred in the same cycle as sync SHALL be taken as a new low byte, leaving the FSM in HI.
REQ-026 flush SHALL set count to 0, both pointers to 0, the FSM to LO and frag_err to 0.
REQ-027 flush SHALL override push, pop, sync and byte transfer in the same cycle.
REQ-028 frag_err SHALL remain set until reset or flush.

Reset
REQ-029 When reset is 1 at a clock edge: FSM = LO, pointers = 0, count = 0, insn_valid = 0, insn = 16'h0000, frag_err = 0, and byte_ready = 1 from the next cycle.
REQ-030 reset SHALL take priority over all other inputs, including mid-word (HI) and full-FIFO states.
REQ-031 The held low byte and FIFO storage contents need not be reset.

Verification
REQ-032 Basic pairing: bytes 0x23, 0x45 on consecutive cycles with insn_ready = 0 -> insn = 0x4523, insn_valid = 1, count = 1.
REQ-033 Full backpressure: DEPTH = 4, insn_ready = 0, 8 bytes then a 9th and 10th byte held valid -> count = 4, byte_ready = 0 after the 9th byte is latched, and the 10th is not accepted until one pop.
REQ-034 Order and wrap: stream 6 words (0x0101..0x0606) with insn_ready toggling every cycle -> words pop in order, count never exceeds 4, and pointers wrap without loss.
REQ-035 Resync: byte 0xAA, then sync with no byte, then bytes 0x11, 0x22 -> frag_err = 1 and insn = 0x2211.
REQ-036 Flush: 3 words stored plus the FSM in HI, then flush with byte_valid = 1 and insn_ready = 1 -> count = 0, insn_valid = 0, FSM in LO, frag_err = 0.
REQ-037 Reset mid-word: byte 0x7F, then reset, then bytes 0x01, 0x80 -> insn = 0x8001 and count = 1.
